// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register bank.
//   - Default data width and register count.
//   - estado codes that open the execution window (reads and writes allowed).
//   - State encoding for the serial dump controller.
package rf_pkg;

  localparam int RF_XLEN_DEFAULT = 32;
  localparam int RF_NREG_DEFAULT = 32;

  // Control-unit states in which the bank is accessed.
  localparam logic [3:0] ESTADO_EX_A = 4'b0010;
  localparam logic [3:0] ESTADO_EX_B = 4'b0101;
  localparam logic [3:0] ESTADO_EX_C = 4'b0110;
  localparam logic [3:0] ESTADO_EX_D = 4'b0111;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/rf_dump_ctrl.sv
// Serial dump controller: walks register indices 0..NREG-1 and presents one
// beat per index on a valid/ready handshake.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   dump_start     start a dump (only honoured while idle)
//   dump_ready     consumer accepts the current beat
//   data_in        bank value (with write bypass) of the index on rd_addr
//   rd_addr        index whose value is captured when a beat is loaded
//   dump_busy      dump in progress
//   dump_valid     current beat valid
//   dump_idx       index of the current beat
//   dump_data      value of the current beat
//   dump_done      one-cycle pulse after the last beat is accepted
module rf_dump_ctrl
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN_DEFAULT,
  parameter int NREG = RF_NREG_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dump_start,
  input  logic                     dump_ready,
  input  logic [XLEN-1:0]          data_in,
  output logic [$clog2(NREG)-1:0]  rd_addr,
  output logic                     dump_busy,
  output logic                     dump_valid,
  output logic [$clog2(NREG)-1:0]  dump_idx,
  output logic [XLEN-1:0]          dump_data,
  output logic                     dump_done
);

  localparam int AW = $clog2(NREG);

  dump_state_t state, state_next;
  logic        load;
  logic        last;

  assign last = (dump_idx == AW'(NREG - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= DUMP_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    load       = 1'b0;
    rd_addr    = '0;
    case (state)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_next = DUMP_SEND;
          load       = 1'b1;
        end
      end
      DUMP_SEND: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        rd_addr    = dump_idx + AW'(1);
        if (dump_ready) begin
          if (last) state_next = DUMP_DONE;
          else      load       = 1'b1;
        end
      end
      DUMP_DONE: begin
        dump_done  = 1'b1;
        state_next = DUMP_IDLE;
      end
      default: state_next = DUMP_IDLE;
    endcase
  end

  // Beat registers only change on load, so a stalled beat stays frozen even
  // if the bank entry behind it is rewritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dump_idx  <= '0;
      dump_data <= '0;
    end else if (load) begin
      dump_idx  <= rd_addr;
      dump_data <= data_in;
    end
  end

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register bank for the multi-cycle datapath: NREG x XLEN
// storage, two registered read ports, one write-back port (ALU or memory
// data), optional hardwired x0, write-first bypass and a serial dump port.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   estado                control-unit state; access only in execution states
//   rs1, rs2, rd          read addresses and write address
//   regiwrite, memtoreg   write enable and source select (1 = readdataM)
//   aluresult, readdataM  write-back data candidates
//   readdata1, readdata2  registered read data
//   dump_*                serial dump handshake (see rf_dump_ctrl)
module banco_registradores_param
  import rf_pkg::*;
#(
  parameter int XLEN           = RF_XLEN_DEFAULT,
  parameter int NREG           = RF_NREG_DEFAULT,
  parameter int ESTADO_W       = 4,
  parameter bit ZERO_REG       = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ESTADO_W-1:0]      estado,
  input  logic [$clog2(NREG)-1:0]  rs1,
  input  logic [$clog2(NREG)-1:0]  rs2,
  input  logic [$clog2(NREG)-1:0]  rd,
  input  logic                     regiwrite,
  input  logic                     memtoreg,
  input  logic [XLEN-1:0]          aluresult,
  input  logic [XLEN-1:0]          readdataM,
  output logic [XLEN-1:0]          readdata1,
  output logic [XLEN-1:0]          readdata2,
  input  logic                     dump_start,
  output logic                     dump_busy,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [$clog2(NREG)-1:0]  dump_idx,
  output logic [XLEN-1:0]          dump_data,
  output logic                     dump_done
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] bank [NREG];
  logic            ex;
  logic            wr_en;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] val1, val2, val_dump;
  logic [AW-1:0]   dump_addr;

  assign ex = estado inside {ESTADO_W'(ESTADO_EX_A), ESTADO_W'(ESTADO_EX_B),
                             ESTADO_W'(ESTADO_EX_C), ESTADO_W'(ESTADO_EX_D)};

  assign wr_en = ex && regiwrite && !(ZERO_REG && (rd == '0));
  assign wdata = memtoreg ? readdataM : aluresult;

  // Value seen by any reader: hardwired zero, then same-cycle write, then bank.
  function automatic logic [XLEN-1:0] read_value(
    input logic [AW-1:0]   a,
    input logic [XLEN-1:0] stored,
    input logic            we,
    input logic [AW-1:0]   waddr,
    input logic [XLEN-1:0] wd
  );
    if (ZERO_REG && (a == '0)) return '0;
    if (we && (waddr == a))    return wd;
    return stored;
  endfunction

  assign val1     = read_value(rs1,       bank[rs1],       wr_en, rd, wdata);
  assign val2     = read_value(rs2,       bank[rs2],       wr_en, rd, wdata);
  assign val_dump = read_value(dump_addr, bank[dump_addr], wr_en, rd, wdata);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) begin
        for (int unsigned i = 0; i < NREG; i++) bank[i] <= '0;
      end
    end else if (wr_en) begin
      bank[rd] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readdata1 <= '0;
      readdata2 <= '0;
    end else if (ex) begin
      readdata1 <= val1;
      readdata2 <= val2;
    end
  end

  rf_dump_ctrl #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .data_in    (val_dump),
    .rd_addr    (dump_addr),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

endmodule
